// File: rtl/branch_unit.sv
// branch_unit: flag register and branch resolver with counted flush window; optional counters via BRANCH_UNIT_STATS_EN
module branch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  cmp_valid,
  input  logic                  zero_in,
  input  logic                  less_in,
  input  logic                  greater_in,
  input  logic                  br_valid,
  input  logic [2:0]            br_cond,
  input  logic [ADDR_WIDTH-1:0] br_target,
  output logic                  taken,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic                  busy,
  output logic [2:0]            flags_q
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [15:0]           br_count,
  output logic [15:0]           taken_count
`endif
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_n;
  logic [3:0] flush_cnt, flush_cnt_n;
  logic accept, cond_ok, take;
  logic z, l, g;
  assign {g, l, z} = flags_q;
  assign accept = !stall && state == IDLE;
  assign take = accept && br_valid && cond_ok;
  assign busy = state == FLUSH;
  assign flush = busy;
  // condition evaluation against the registered flags only
  always_comb begin
    cond_ok = 1'b0;
    case (br_cond)
      3'b000: cond_ok = 1'b1;
      3'b001: cond_ok = z;
      3'b010: cond_ok = !z;
      3'b011: cond_ok = l;
      3'b100: cond_ok = l | z;
      3'b101: cond_ok = g;
      3'b110: cond_ok = g | z;
      default: cond_ok = 1'b0;
    endcase
  end
  // next state: a taken branch opens the flush window, which counts down regardless of stall
  always_comb begin
    state_n = state;
    flush_cnt_n = flush_cnt;
    if (state == IDLE) begin
      state_n = take ? FLUSH : IDLE;
      flush_cnt_n = take ? 4'(FLUSH_CYCLES - 1) : flush_cnt;
    end else begin
      state_n = flush_cnt == 4'd0 ? IDLE : FLUSH;
      flush_cnt_n = flush_cnt == 4'd0 ? 4'd0 : flush_cnt - 4'd1;
    end
  end
  // state, flags and registered redirect outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      flush_cnt <= 4'd0;
      flags_q <= 3'b000;
      taken <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state <= state_n;
      flush_cnt <= flush_cnt_n;
      taken <= take;
      if (take) redirect_pc <= br_target;
      if (accept && cmp_valid) flags_q <= {greater_in, less_in, zero_in};
    end
  end
`ifdef BRANCH_UNIT_STATS_EN
  // branch and taken counters, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count <= 16'd0;
      taken_count <= 16'd0;
    end else begin
      if (accept && br_valid && br_cond != 3'b111) br_count <= br_count + 16'd1;
      if (take) taken_count <= taken_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed and randomized check of branch_unit against a cycle-level reference model
module tb_branch_unit;
  localparam int AW = 16;
  localparam int FC = 2;
  logic clk = 1'b0;
  logic reset, stall, cmp_valid, zero_in, less_in, greater_in, br_valid;
  logic [2:0] br_cond;
  logic [AW-1:0] br_target;
  logic taken, flush, busy;
  logic [AW-1:0] redirect_pc;
  logic [2:0] flags_q;
  int n_chk = 0;
  int n_fail = 0;
  logic [2:0] m_flags = 3'b000;
  logic m_taken = 1'b0;
  logic [AW-1:0] m_pc = '0;
  int m_left = 0;
`ifdef BRANCH_UNIT_STATS_EN
  logic [15:0] br_count, taken_count;
  logic [15:0] m_br = 16'd0;
  logic [15:0] m_tk = 16'd0;
`endif
  branch_unit #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .cmp_valid(cmp_valid),
    .zero_in(zero_in), .less_in(less_in), .greater_in(greater_in),
    .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
    .taken(taken), .redirect_pc(redirect_pc), .flush(flush), .busy(busy),
    .flags_q(flags_q)
`ifdef BRANCH_UNIT_STATS_EN
    , .br_count(br_count), .taken_count(taken_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
    logic zf, lf, gf;
    {gf, lf, zf} = f;
    case (c)
      3'd0: return 1'b1;
      3'd1: return zf;
      3'd2: return !zf;
      3'd3: return lf;
      3'd4: return lf || zf;
      3'd5: return gf;
      3'd6: return gf || zf;
      default: return 1'b0;
    endcase
  endfunction
  task automatic step(input logic r, s, cv, zi, li, gi, bv, input logic [2:0] c, input logic [AW-1:0] t);
    logic acc;
    reset = r; stall = s; cmp_valid = cv; zero_in = zi; less_in = li; greater_in = gi;
    br_valid = bv; br_cond = c; br_target = t;
    @(posedge clk);
    if (r) begin
      m_flags = 3'b000; m_taken = 1'b0; m_pc = '0; m_left = 0;
`ifdef BRANCH_UNIT_STATS_EN
      m_br = 16'd0; m_tk = 16'd0;
`endif
    end else begin
      acc = !s && m_left == 0;
      m_taken = acc && bv && cond_true(c, m_flags);
`ifdef BRANCH_UNIT_STATS_EN
      if (acc && bv && c != 3'd7) m_br++;
      if (m_taken) m_tk++;
`endif
      if (m_taken) begin
        m_pc = t;
        m_left = FC;
      end else if (m_left > 0) m_left--;
      if (acc && cv) m_flags = {gi, li, zi};
    end
    #1;
    chk("taken", 32'(taken), 32'(m_taken));
    chk("redirect_pc", 32'(redirect_pc), 32'(m_pc));
    chk("flush", 32'(flush), 32'(m_left > 0));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("flags_q", 32'(flags_q), 32'(m_flags));
`ifdef BRANCH_UNIT_STATS_EN
    chk("br_count", 32'(br_count), 32'(m_br));
    chk("taken_count", 32'(taken_count), 32'(m_tk));
`endif
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 3'd0, '0);
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 3'd0, '0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);
    step(0, 0, 1, 1, 0, 0, 0, 3'd0, '0);
    chk("cmp_zero", 32'(flags_q), 32'b001);
    step(0, 0, 0, 0, 0, 0, 1, 3'd1, 16'h0040);
    chk("je_taken", 32'(taken), 32'd1);
    chk("je_pc", 32'(redirect_pc), 32'h0040);
    idle();
    chk("je_flush2", 32'(flush), 32'd1);
    chk("je_pulse", 32'(taken), 32'd0);
    idle();
    chk("je_flush_end", 32'(flush), 32'd0);
    step(0, 0, 1, 0, 1, 0, 0, 3'd0, '0);
    chk("cmp_less", 32'(flags_q), 32'b010);
    step(0, 0, 0, 0, 0, 0, 1, 3'd6, 16'h0100);
    chk("jge_not", 32'(taken), 32'd0);
    chk("jge_noflush", 32'(flush), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1, 3'd4, 16'h0100);
    chk("jle_taken", 32'(taken), 32'd1);
    chk("jle_pc", 32'(redirect_pc), 32'h0100);
    idle(); idle();
    step(0, 0, 0, 0, 0, 0, 1, 3'd0, 16'h0010);
    chk("jmp_taken", 32'(taken), 32'd1);
    step(0, 0, 1, 1, 0, 0, 1, 3'd0, 16'h0020);
    chk("flush_ign_br", 32'(taken), 32'd0);
    chk("flush_ign_cmp", 32'(flags_q), 32'b010);
    chk("flush_busy", 32'(busy), 32'd1);
    idle();
    chk("busy_drop", 32'(busy), 32'd0);
    step(0, 0, 1, 0, 0, 0, 0, 3'd0, '0);
    step(0, 0, 1, 0, 0, 1, 1, 3'd5, 16'h0080);
    chk("jg_old_flags", 32'(taken), 32'd0);
    chk("jg_new_flags", 32'(flags_q), 32'b100);
    step(0, 0, 0, 0, 0, 0, 1, 3'd5, 16'h0080);
    chk("jg_taken", 32'(taken), 32'd1);
    idle(); idle();
    step(0, 1, 0, 0, 0, 0, 1, 3'd0, 16'h0200);
    chk("stall_jmp", 32'(taken), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1, 3'd0, 16'h0300);
    chk("jmp2_taken", 32'(taken), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 3'd0, '0);
    chk("rst_mid_flush", 32'(flush), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_flags", 32'(flags_q), 32'd0);
    chk("rst_mid_pc", 32'(redirect_pc), 32'd0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
